// File: rtl/square_root_pkg.sv
// ---------------------------------------------------------------------------
// square_root_pkg
// Shared definitions for the sequential integer square-root unit: the
// default operand width, the pass state encoding, and the widths derived
// from the default operand width.
// ---------------------------------------------------------------------------
package square_root_pkg;

  localparam int DEF_WIDTH = 8;

  // Result has half the radicand bits; the partial remainder needs two
  // extra bits to hold (rem << 2) | pair before the trial subtraction.
  localparam int ROOT_W = DEF_WIDTH / 2;
  localparam int REM_W  = DEF_WIDTH / 2 + 2;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sqrt_step.sv
// ---------------------------------------------------------------------------
// sqrt_step
// One iteration of the restoring digit-by-digit square root. Purely
// combinational.
//   rem_i   partial remainder from the previous iteration
//   root_i  partial root from the previous iteration
//   pair_i  next (most significant remaining) radicand bit pair
//   rem_o   partial remainder after this iteration
//   root_o  partial root after this iteration (one more result bit)
// ---------------------------------------------------------------------------
module sqrt_step
  import square_root_pkg::*;
#(
  parameter int RW = ROOT_W
) (
  input  logic [RW+1:0] rem_i,
  input  logic [RW-1:0] root_i,
  input  logic [1:0]    pair_i,
  output logic [RW+1:0] rem_o,
  output logic [RW-1:0] root_o
);

  logic [RW+1:0] r;
  logic [RW+1:0] t;

  // rem is bounded by 2*root, so its top two bits are always zero while
  // iterations remain and dropping them in the shift loses nothing.
  assign r = (RW+2)'({rem_i, pair_i});
  assign t = {root_i, 2'b01};

  always_comb begin
    if (r >= t) begin
      rem_o  = r - t;
      root_o = RW'({root_i, 1'b1});
    end else begin
      rem_o  = r;
      root_o = RW'({root_i, 1'b0});
    end
  end

endmodule

// File: rtl/square_root.sv
// ---------------------------------------------------------------------------
// square_root
// Free-running sequential floor(sqrt) unit. Each pass is LOAD (sample the
// radicand), WIDTH/2 ITER cycles (one result bit each, MSB first) and DONE
// (publish the result). SquareRoot only changes on the DONE edge.
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   Radicand    unsigned operand, sampled only in LOAD
//   SquareRoot  registered floor(sqrt) of the last sampled radicand
// ---------------------------------------------------------------------------
module square_root
  import square_root_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Radicand,
  output logic [WIDTH-1:0] SquareRoot
);

  localparam int RW = WIDTH / 2;
  localparam int MW = RW + 2;
  localparam int CW = (RW > 1) ? $clog2(RW) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(RW - 1);

  state_e           state_q;
  logic [WIDTH-1:0] rad_q;
  logic [MW-1:0]    rem_q;
  logic [MW-1:0]    rem_d;
  logic [RW-1:0]    root_q;
  logic [RW-1:0]    root_d;
  logic [CW-1:0]    cnt_q;

  sqrt_step #(
    .RW(RW)
  ) u_step (
    .rem_i (rem_q),
    .root_i(root_q),
    .pair_i(rad_q[WIDTH-1 -: 2]),
    .rem_o (rem_d),
    .root_o(root_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      rad_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      cnt_q      <= '0;
      SquareRoot <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          rad_q   <= Radicand;
          rem_q   <= '0;
          root_q  <= '0;
          cnt_q   <= CNT_INIT;
          state_q <= ITER;
        end
        ITER: begin
          rem_q  <= rem_d;
          root_q <= root_d;
          // Consumed pair leaves the top; next pair moves into position.
          rad_q  <= rad_q << 2;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          SquareRoot <= {{(WIDTH - RW){1'b0}}, root_q};
          state_q    <= LOAD;
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_root.sv
// ---------------------------------------------------------------------------
// tb_square_root
// Self-checking bench for square_root (WIDTH=8). Expected results come from
// an integer floor-sqrt function and a pass-timing model: after reset the
// radicand is sampled on edges 1, 7, 13, ... and published on edges
// 6, 12, 18, ...
// ---------------------------------------------------------------------------
module tb_square_root;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] rad = '0;
  logic [W-1:0] sq;

  square_root #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Radicand  (rad),
    .SquareRoot(sq)
  );

  always #5 clk = ~clk;

  int           vectors     = 0;
  int           miscompares = 0;
  int           cyc         = 0;
  logic [W-1:0] hist [0:8191];

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return W'(r);
  endfunction

  // Output after rising edge n (counted from reset release).
  function automatic logic [W-1:0] model(input int n);
    int done_edge;
    if (n < 6) return '0;
    done_edge = (n / 6) * 6;
    return isqrt(int'(hist[done_edge - 5]));
  endfunction

  task automatic step();
    hist[cyc + 1] = rad;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_clear", sq, '0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  always @(negedge clk) begin
    check("upper_zero", {4'b0, sq[7:4]}, '0);
  end

  initial begin
    int k;
    int vals [9] = '{0, 1, 3, 4, 15, 16, 224, 225, 255};
    int hold;

    // Reset held with a nonzero radicand.
    rad = 8'd200;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_hold", sq, '0);
    end
    rst = 1'b0;
    cyc = 0;
    repeat (12) begin
      step();
      check("rst_release_model", sq, model(cyc));
    end
    check("rst_release_200", sq, 8'd14);

    // Zero from reset, then 7 applied 100 ns later.
    rad = 8'd0;
    do_reset();
    repeat (10) begin
      step();
      check("zero_model", sq, model(cyc));
    end
    rad = 8'd7;
    k = 0;
    while (sq !== 8'd2 && k < 11) begin
      step();
      k++;
    end
    check("seven_within_11", sq, 8'd2);
    repeat (8) begin
      step();
      check("seven_stable", sq, 8'd2);
    end

    // Boundary sweep then exhaustive sweep, each value held 12 cycles.
    do_reset();
    foreach (vals[i]) begin
      rad = W'(vals[i]);
      repeat (12) begin
        step();
        check("sweep_model", sq, model(cyc));
      end
      check("sweep_boundary", sq, isqrt(vals[i]));
    end
    for (int v = 0; v < 256; v++) begin
      rad = W'(v);
      repeat (12) begin
        step();
        check("exh_model", sq, model(cyc));
      end
      check("exhaustive", sq, isqrt(v));
    end

    // Input change right after LOAD is ignored for the pass in progress.
    rad = 8'd100;
    do_reset();
    step();
    rad = 8'd9;
    repeat (5) step();
    check("chg_first_done", sq, 8'd10);
    repeat (5) step();
    check("chg_before_second", sq, 8'd10);
    step();
    check("chg_second_done", sq, 8'd3);

    // Asynchronous reset during ITER aborts the pass.
    rad = 8'd81;
    do_reset();
    repeat (12) step();
    check("pre_abort_81", sq, 8'd9);
    repeat (2) step();
    #1 rst = 1'b1;
    #1 check("async_reset", sq, '0);
    @(negedge clk);
    check("async_reset_held", sq, '0);
    rst = 1'b0;
    cyc = 0;
    repeat (5) step();
    check("post_abort_pending", sq, '0);
    step();
    check("post_abort_81", sq, 8'd9);

    // Random radicands with random hold times against the timing model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      rad  = W'($urandom);
      hold = int'($urandom_range(1, 8));
      repeat (hold) begin
        step();
        check("random_model", sq, model(cyc));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
